// File: rtl/sys_bus.sv
// sys_bus: single-master bus fabric sitting behind the CPU core.
// It decodes every strobe/acknowledge cycle to one of three targets: the
// internal byte-laned block RAM, the external 64 KiB peripheral window, or the
// error responder for unmapped addresses. The acknowledge is four-phase: ack_o
// is held while stb_i stays high and is released one cycle after stb_i drops.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_i      - asynchronous active-high reset
//   stb_i      - CPU cycle strobe
//   we_i       - CPU write enable
//   adr_i      - CPU byte address
//   dat_i      - CPU write data
//   sel_i      - CPU byte lanes (bit n -> bits [8n+7:8n])
//   ack_o      - acknowledge to CPU
//   dat_o      - read data to CPU
//   io_stb_o   - peripheral strobe
//   io_we_o    - peripheral write enable
//   io_adr_o   - peripheral byte offset (adr_i[15:0])
//   io_dat_o   - peripheral write data
//   io_sel_o   - peripheral byte lanes
//   io_dat_i   - peripheral read data, valid with io_ack_i
//   io_ack_i   - peripheral acknowledge
//   bus_err_o  - one-cycle pulse on unmapped access or peripheral timeout
//   err_adr_o  - address of the most recent erroring access
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for stb_i; decodes and latches the cycle
// S_RAM_RD  | one-cycle wait for the synchronous RAM read word
// S_IO_WAIT | io_stb_o high, waiting for io_ack_i or the timeout count
// S_ACK     | ack_o high, waiting for the core to drop stb_i

module sys_bus #(
    parameter int unsigned RAM_AW  = 12,
    parameter logic [31:0] IO_BASE = 32'hF000_0000,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    output logic        ack_o,
    output logic [31:0] dat_o,
    output logic        io_stb_o,
    output logic        io_we_o,
    output logic [15:0] io_adr_o,
    output logic [31:0] io_dat_o,
    output logic [3:0]  io_sel_o,
    input  logic [31:0] io_dat_i,
    input  logic        io_ack_i,
    output logic        bus_err_o,
    output logic [31:0] err_adr_o
);

    localparam int unsigned RAM_WORDS = 1 << RAM_AW;
    localparam logic [15:0] TO_CNT    = 16'(TIMEOUT);
    localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAM_RD,
        S_IO_WAIT,
        S_ACK
    } state_t;

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        io_stb_q, io_stb_d;
    logic        io_we_q, io_we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] io_dat_q, io_dat_d;
    logic [3:0]  io_sel_q, io_sel_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] err_adr_q, err_adr_d;
    logic [15:0] cnt_q, cnt_d;

    logic              ram_hit;
    logic              io_hit;
    logic              ram_wr;
    logic              ram_rd;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram_rdata;
    logic [31:0]       mem [RAM_WORDS];

    // Decode works on word addresses; adr_i[1:0] only matters to peripherals.
    assign ram_hit = (adr_i[31:RAM_AW+2] == '0);
    assign io_hit  = (adr_i[31:16] == IO_BASE[31:16]);
    assign ram_idx = adr_i[RAM_AW+1:2];

    // Block RAM: no reset so it maps onto RAM primitives. Strobes are gated
    // with rst_i so a strobe seen during reset cannot corrupt contents.
    always_ff @(posedge clk) begin
        if (ram_wr && !rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_i[b]) begin
                    mem[ram_idx][8*b +: 8] <= dat_i[8*b +: 8];
                end
            end
        end
        if (ram_rd && !rst_i) begin
            ram_rdata <= mem[ram_idx];
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            io_stb_q  <= 1'b0;
            io_we_q   <= 1'b0;
            adr_q     <= '0;
            io_dat_q  <= '0;
            io_sel_q  <= '0;
            bus_err_q <= 1'b0;
            err_adr_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            io_stb_q  <= io_stb_d;
            io_we_q   <= io_we_d;
            adr_q     <= adr_d;
            io_dat_q  <= io_dat_d;
            io_sel_q  <= io_sel_d;
            bus_err_q <= bus_err_d;
            err_adr_q <= err_adr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        dat_d     = dat_q;
        io_stb_d  = io_stb_q;
        io_we_d   = io_we_q;
        adr_d     = adr_q;
        io_dat_d  = io_dat_q;
        io_sel_d  = io_sel_q;
        bus_err_d = 1'b0;
        err_adr_d = err_adr_q;
        cnt_d     = cnt_q;
        ram_wr    = 1'b0;
        ram_rd    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (stb_i) begin
                    if (ram_hit) begin
                        if (we_i) begin
                            ram_wr  = 1'b1;
                            ack_d   = 1'b1;
                            state_d = S_ACK;
                        end else begin
                            ram_rd  = 1'b1;
                            state_d = S_RAM_RD;
                        end
                    end else if (io_hit) begin
                        io_stb_d = 1'b1;
                        io_we_d  = we_i;
                        adr_d    = adr_i;
                        io_dat_d = dat_i;
                        io_sel_d = sel_i;
                        cnt_d    = '0;
                        state_d  = S_IO_WAIT;
                    end else begin
                        dat_d     = ERR_DATA;
                        ack_d     = 1'b1;
                        bus_err_d = 1'b1;
                        err_adr_d = adr_i;
                        state_d   = S_ACK;
                    end
                end
            end

            S_RAM_RD: begin
                dat_d   = ram_rdata;
                ack_d   = 1'b1;
                state_d = S_ACK;
            end

            S_IO_WAIT: begin
                // A peripheral ack on the timeout cycle still completes cleanly.
                if (io_ack_i) begin
                    io_stb_d = 1'b0;
                    ack_d    = 1'b1;
                    if (!io_we_q) begin
                        dat_d = io_dat_i;
                    end
                    state_d = S_ACK;
                end else if (cnt_q == TO_CNT) begin
                    io_stb_d  = 1'b0;
                    dat_d     = ERR_DATA;
                    ack_d     = 1'b1;
                    bus_err_d = 1'b1;
                    err_adr_d = adr_q;
                    state_d   = S_ACK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_ACK: begin
                if (!stb_i) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign ack_o     = ack_q;
    assign dat_o     = dat_q;
    assign io_stb_o  = io_stb_q;
    assign io_we_o   = io_we_q;
    assign io_adr_o  = adr_q[15:0];
    assign io_dat_o  = io_dat_q;
    assign io_sel_o  = io_sel_q;
    assign bus_err_o = bus_err_q;
    assign err_adr_o = err_adr_q;

endmodule

// File: tb/tb_sys_bus.sv
// Directed testbench for sys_bus (TIMEOUT overridden to 4).
module tb_sys_bus;

    localparam logic [31:0] IO_BASE = 32'hF000_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        stb_i;
    logic        we_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic        ack_o;
    logic [31:0] dat_o;
    logic        io_stb_o;
    logic        io_we_o;
    logic [15:0] io_adr_o;
    logic [31:0] io_dat_o;
    logic [3:0]  io_sel_o;
    logic [31:0] io_dat_i;
    logic        io_ack_i;
    logic        bus_err_o;
    logic [31:0] err_adr_o;

    int n_checks = 0;
    int n_fail   = 0;
    int io_lat   = 0;   // edge index (from acceptance) at which io_ack_i is sampled; 0 = never

    sys_bus #(
        .RAM_AW (12),
        .IO_BASE(IO_BASE),
        .TIMEOUT(4)
    ) dut (
        .clk      (clk),
        .rst_i    (rst_i),
        .stb_i    (stb_i),
        .we_i     (we_i),
        .adr_i    (adr_i),
        .dat_i    (dat_i),
        .sel_i    (sel_i),
        .ack_o    (ack_o),
        .dat_o    (dat_o),
        .io_stb_o (io_stb_o),
        .io_we_o  (io_we_o),
        .io_adr_o (io_adr_o),
        .io_dat_o (io_dat_o),
        .io_sel_o (io_sel_o),
        .io_dat_i (io_dat_i),
        .io_ack_i (io_ack_i),
        .bus_err_o(bus_err_o),
        .err_adr_o(err_adr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full core cycle, entered and left at posedge+1.
    // lat = edges from acceptance (edge 0) until ack_o is seen, counting edge 0 as 1.
    task automatic bus_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input int hold,
                             output logic [31:0] rd, output int lat, output int errs,
                             output int stbs, output logic [15:0] ioadr, output logic err_at_ack);
        bit done;
        done = 0; rd = '0; lat = 0; errs = 0; stbs = 0; ioadr = '0; err_at_ack = 1'b0;
        stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
            io_ack_i = (io_lat > 0) && (k + 1 == io_lat);
            if (io_stb_o) begin
                stbs++;
                ioadr = io_adr_o;
            end
            if (bus_err_o) errs++;
            if (ack_o) begin
                done = 1;
                lat = k + 1;
                rd = dat_o;
                err_at_ack = bus_err_o;
            end
        end
        io_ack_i = 1'b0;
        check("ack_seen", done, 1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (bus_err_o) errs++;
            check("ack_hold", ack_o, 1);
            check("dat_hold", dat_o, rd);
        end
        stb_i = 1'b0;
        @(posedge clk); #1;
        if (bus_err_o) errs++;
        check("ack_fall", ack_o, 0);
    endtask

    logic [31:0] rd;
    int          lat, errs, stbs;
    logic [15:0] ioadr;
    logic        eaa;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; stb_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0; sel_i = '0;
        io_dat_i = '0; io_ack_i = 1'b0;
        #2;
        check("rst_ack", ack_o, 0);
        check("rst_dat", dat_o, 0);
        check("rst_iostb", io_stb_o, 0);
        check("rst_err", bus_err_o, 0);
        check("rst_erradr", err_adr_o, 0);
        check("rst_ioadr", io_adr_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        // RAM byte-lane writes and readback
        bus_cycle(1'b1, 32'h10, 32'h1122_3344, 4'b1111, 0, rd, lat, errs, stbs, ioadr, eaa);
        check("ramwr1_lat", lat, 1);
        bus_cycle(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, 0, rd, lat, errs, stbs, ioadr, eaa);
        check("ramwr2_lat", lat, 1);
        bus_cycle(1'b0, 32'h10, 32'h0, 4'b0000, 0, rd, lat, errs, stbs, ioadr, eaa);
        check("ramrd_lat", lat, 2);
        check("ramrd_dat", rd, 32'h11BB_33DD);

        // IO read, peripheral acks at edge 3, ack held 3 extra cycles
        io_lat = 3; io_dat_i = 32'hCAFE_0001;
        bus_cycle(1'b0, IO_BASE + 32'h24, 32'h0, 4'b1111, 3, rd, lat, errs, stbs, ioadr, eaa);
        check("iord_lat", lat, 4);
        check("iord_dat", rd, 32'hCAFE_0001);
        check("iord_adr", ioadr, 16'h0024);
        check("iord_stbs", stbs, 3);
        check("iord_errs", errs, 0);
        check("iord_iostb_low", io_stb_o, 0);

        // Unmapped read
        io_lat = 0;
        bus_cycle(1'b0, 32'h8000_0000, 32'h0, 4'b1111, 1, rd, lat, errs, stbs, ioadr, eaa);
        check("unm_lat", lat, 1);
        check("unm_dat", rd, 32'hDEAD_BEEF);
        check("unm_errs", errs, 1);
        check("unm_err_at_ack", eaa, 1);
        check("unm_erradr", err_adr_o, 32'h8000_0000);

        // Peripheral timeout on a write
        io_lat = 0;
        bus_cycle(1'b1, IO_BASE + 32'h40, 32'h5555_AAAA, 4'b0011, 0, rd, lat, errs, stbs, ioadr, eaa);
        check("to_lat", lat, 6);
        check("to_stbs", stbs, 5);
        check("to_errs", errs, 1);
        check("to_err_at_ack", eaa, 1);
        check("to_dat", rd, 32'hDEAD_BEEF);
        check("to_erradr", err_adr_o, IO_BASE + 32'h40);
        check("to_iowe", io_we_o, 1);
        check("to_iodat", io_dat_o, 32'h5555_AAAA);
        check("to_iosel", io_sel_o, 4'b0011);

        // Peripheral ack on the timeout cycle wins
        io_lat = 5;
        bus_cycle(1'b1, IO_BASE + 32'h44, 32'h1234_5678, 4'b1111, 0, rd, lat, errs, stbs, ioadr, eaa);
        check("race_lat", lat, 6);
        check("race_errs", errs, 0);
        check("race_dat_unchanged", rd, 32'hDEAD_BEEF);
        check("race_erradr_held", err_adr_o, IO_BASE + 32'h40);

        // Back-to-back alternating RAM writes and IO reads
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                io_lat = 0;
                bus_cycle(1'b1, 32'h100 + 32'(4 * i), 32'h1000_0000 + 32'(i), 4'b1111, 0,
                          rd, lat, errs, stbs, ioadr, eaa);
                check("b2b_ram_lat", lat, 1);
            end else begin
                io_lat = 2; io_dat_i = 32'hC0DE_0000 + 32'(i);
                bus_cycle(1'b0, IO_BASE + 32'(4 * i), 32'h0, 4'b1111, 0,
                          rd, lat, errs, stbs, ioadr, eaa);
                check("b2b_io_lat", lat, 3);
                check("b2b_io_dat", rd, 32'hC0DE_0000 + 32'(i));
                check("b2b_io_adr", ioadr, 16'(4 * i));
            end
            check("b2b_errs", errs, 0);
        end
        io_lat = 0;
        bus_cycle(1'b0, 32'h108, 32'h0, 4'b0000, 0, rd, lat, errs, stbs, ioadr, eaa);
        check("b2b_readback", rd, 32'h1000_0002);

        // Protocol violation: stb drops during RAM_RD, ack pulses once
        stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h100;
        @(posedge clk); #1;
        stb_i = 1'b0;
        @(posedge clk); #1;
        check("early_ack", ack_o, 1);
        check("early_dat", dat_o, 32'h1000_0000);
        @(posedge clk); #1;
        check("early_ack_fall", ack_o, 0);

        // Reset asserted mid IO_WAIT
        io_lat = 0;
        stb_i = 1'b1; we_i = 1'b0; adr_i = IO_BASE + 32'h8;
        @(posedge clk); #1;
        check("midrst_iostb_hi", io_stb_o, 1);
        @(posedge clk); #3;
        rst_i = 1'b1;
        #1;
        check("midrst_iostb", io_stb_o, 0);
        check("midrst_ack", ack_o, 0);
        check("midrst_dat", dat_o, 0);
        check("midrst_erradr", err_adr_o, 0);
        check("midrst_err", bus_err_o, 0);
        stb_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        bus_cycle(1'b0, 32'h10, 32'h0, 4'b0000, 0, rd, lat, errs, stbs, ioadr, eaa);
        check("postrst_lat", lat, 2);
        check("postrst_dat", rd, 32'h11BB_33DD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_bus.md
# sys_bus

Single-master system bus fabric that sits directly downstream of the CPU core. It accepts the core's strobe/acknowledge bus cycles and decodes each one to one of three targets: an internal byte-laned block RAM, an external peripheral port, or an unmapped-region error responder. It returns read data and a four-phase acknowledge that matches the core's protocol: `ack` is held while `stb` is high and released after `stb` drops.

## Interface
- `RAM_AW`, default 12: RAM word-address width; RAM holds 2^RAM_AW 32-bit words at byte addresses 0 .. 4*2^RAM_AW-1.
- `IO_BASE`, default 32'hF000_0000: base of the 64 KiB peripheral window (IO_BASE .. IO_BASE+32'h0000_FFFF); must be 64 KiB aligned.
- `TIMEOUT`, default 255: cycles spent in IO_WAIT before the fabric aborts the peripheral access; range 1..65535.
- `clk` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `stb_i` in 1: CPU cycle strobe.
- `we_i` in 1: CPU write enable.
- `adr_i` in 32: CPU byte address.
- `dat_i` in 32: CPU write data.
- `sel_i` in 4: CPU byte lanes; bit n selects bits [8n+7:8n].
- `ack_o` out 1: acknowledge to CPU.
- `dat_o` out 32: read data to CPU.
- `io_stb_o` out 1: peripheral strobe.
- `io_we_o` out 1: peripheral write enable.
- `io_adr_o` out 16: peripheral byte offset, equal to adr_i[15:0].
- `io_dat_o` out 32: peripheral write data.
- `io_sel_o` out 4: peripheral byte lanes.
- `io_dat_i` in 32: peripheral read data, valid while `io_ack_i` is high.
- `io_ack_i` in 1: peripheral acknowledge.
- `bus_err_o` out 1: one-cycle pulse on an unmapped access or a peripheral timeout.
- `err_adr_o` out 32: address of the most recent erroring access; holds until the next error.

## Operation
- Reset (async, rst_i=1):
  - All outputs are 0 and the state is IDLE.
  - The timeout counter is cleared.
  - RAM contents are not cleared.
  - An in-flight cycle is abandoned, and io_stb_o drops immediately without waiting for the next clock edge.
- Decode: addresses are compared on adr_i[31:2]; adr_i[1:0] is ignored for RAM and is passed through to io_adr_o.
- States:
  - IDLE
  - RAM_RD: waits one cycle for synchronous RAM read data.
  - IO_WAIT
  - ACK
- In IDLE, when stb_i=1 is sampled, the cycle is latched as follows:
  - **RAM write:** byte lanes with sel_i=1 are written at this edge; lanes with sel_i=0 are preserved. ack_o goes to 1; next state ACK.
  - **RAM read:** RAM is addressed with adr_i[RAM_AW+1:2]; next state RAM_RD.
  - **IO:** io_stb_o goes to 1, and io_we_o, io_adr_o, io_dat_o and io_sel_o are latched. The counter is cleared; next state IO_WAIT.
  - **Unmapped:** dat_o is set to 32'hDEAD_BEEF, ack_o and bus_err_o go to 1, err_adr_o is set to adr_i; next state ACK.
- RAM_RD: dat_o takes the full RAM word (sel_i is ignored on reads) and ack_o goes to 1; next state ACK.
- IO_WAIT:
  - If io_ack_i=1: io_stb_o goes to 0 and ack_o goes to 1. dat_o takes io_dat_i on a read; on a write dat_o is unchanged. Next state ACK.
  - Else, if the counter equals TIMEOUT: io_stb_o goes to 0, dat_o is set to 32'hDEAD_BEEF, ack_o and bus_err_o go to 1, err_adr_o is set to the latched address. Next state ACK.
  - Otherwise the counter increments.
  - If io_ack_i and timeout coincide in the same cycle, io_ack_i wins and no error is raised.
- ACK:
  - While stb_i=1, ack_o stays at 1 and dat_o is held.
  - When stb_i=0 is sampled, ack_o goes to 0; next state IDLE.
  - A new stb_i is never accepted while in ACK.
- stb_i dropping before ack (a protocol violation) does not abort the cycle: it completes, ack_o pulses for exactly one cycle, and the fabric returns to IDLE.
- bus_err_o is high for exactly one cycle per error event.

## Timing
- Cycle 0 denotes the first rising edge at which stb_i=1 is sampled in IDLE. Latency to ack_o=1:
  - RAM write: 1 cycle.
  - Unmapped: 1 cycle.
  - RAM read: 2 cycles.
  - IO: 1 cycle after the edge that samples io_ack_i=1.
  - Timeout: TIMEOUT+1 cycles after io_stb_o rises.
- ack_o falls 1 cycle after stb_i=0 is sampled.
- The minimum gap from ack_o falling to the next stb_i acceptance is 0 cycles: IDLE samples stb_i on the next edge.
- The core holds adr/we/dat/sel stable while stb is high. The fabric latches them at acceptance and does not re-sample them.
- All outputs are registered; there is no combinational path from CPU inputs to CPU outputs.

## Test plan
- **Reset:** assert rst_i mid-IO_WAIT with io_stb_o=1 -> io_stb_o drops before the next clock edge, all outputs are 0, and the next stb_i is accepted normally.
- **RAM byte write:** write 32'h1122_3344 to 0x10 with sel=4'b1111, then 32'hAABB_CCDD with sel=4'b0101, then read 0x10 -> read returns 32'h11BB_33DD with ack at cycle 2; the write acks at cycle 1.
- **IO read:** read IO_BASE+0x24; the peripheral acks 3 cycles after io_stb_o with io_dat_i=32'hCAFE_0001 -> io_adr_o=16'h0024 and dat_o=32'hCAFE_0001. ack_o is held until stb_i drops, then falls 1 cycle later.
- **Unmapped read:** read 0x8000_0000 -> ack at cycle 1 with dat_o=32'hDEAD_BEEF, a single-cycle bus_err_o, and err_adr_o=32'h8000_0000.
- **Timeout:** IO write with no io_ack_i, TIMEOUT=4 -> io_stb_o is high for 5 cycles, then bus_err_o and ack_o rise together and err_adr_o holds the IO address. Repeat with io_ack_i arriving on the timeout cycle -> no error is raised.
- **Back-to-back:** emulate the core's FETCH loop: stb high, drop it 1 cycle after ack, reassert on the next cycle, across 8 alternating RAM/IO accesses -> every access is acked exactly once and there is no overlap between ack_o and a new acceptance.
